vigna_bus_responder: RTL

Responder (slave) end of the vigna valid/ready memory bus: accepts one read or byte-strobed write at a time from the core or from the `bus2to1` arbiter output, services it from an internal word-addressed memory after a fixed number of wait states, and returns a one-cycle `s_ready` pulse. It is the standard on-chip RAM/bench memory attached behind the core's unified bus.

---
 rtl/vigna_bus_pkg.sv | 17 +
 rtl/vigna_sram_1rw.sv | 42 ++++
 rtl/vigna_bus_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vigna_bus_pkg.sv
// vigna_bus_pkg
// Shared definitions for the vigna bus responder and its RAM:
//   - FSM state encoding for the responder
//   - strobe value meaning "read"
//   - wait-state counter width
package vigna_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] STRB_READ = 4'b0000;
  localparam int         CNT_W     = 4;

endpackage

// File: rtl/vigna_sram_1rw.sv
// vigna_sram_1rw
// Single-port synchronous RAM, 32-bit words, byte-lane write enables,
// registered read. Contents are not reset.
// Ports:
//   clk      in  clock
//   i_en     in  access enable for this cycle
//   i_we     in  byte-lane write enables; all zero = read
//   i_idx    in  word index
//   i_wdata  in  write data
//   o_rdata  out read data register (updated only on enabled reads)
module vigna_sram_1rw
  import vigna_bus_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [3:0]       i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we == STRB_READ) begin
        r_q <= r_mem[i_idx];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (i_we[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/vigna_bus_responder.sv
// vigna_bus_responder
// Responder end of the vigna valid/ready bus. Accepts one read or
// byte-strobed write, services it from an internal RAM after WAIT_CYCLES
// wait states and returns a one-cycle s_ready pulse.
// Optional feature: define VIGNA_BUS_RESP_ERR_EN to add an address range
// check and the s_err output; otherwise addresses alias modulo the RAM size.
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   s_valid  in  request present
//   s_ready  out one-cycle completion pulse
//   s_addr   in  byte address (bits [1:0] ignored)
//   s_rdata  out read data, valid with s_ready
//   s_wdata  in  write data
//   s_wstrb  in  byte enables, 0 = read
//   s_err    out out-of-range flag with s_ready (VIGNA_BUS_RESP_ERR_EN only)
//
// state | meaning
// IDLE  | waiting for s_valid; request captured on acceptance
// WAIT  | counting down wait states, inputs ignored
// RESP  | s_ready high for this single cycle
module vigna_bus_responder
  import vigna_bus_pkg::*;
#(
  parameter  int          DEPTH_WORDS = 1024,
  parameter  int          WAIT_CYCLES = 1,
  parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_addr,
  output logic [31:0] s_rdata,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb
`ifdef VIGNA_BUS_RESP_ERR_EN
  ,
  output logic        s_err
`endif
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_ready, r_rd_valid;
  logic             w_capture, w_access;

  logic [31:0]      w_req_addr, w_req_wdata, w_off;
  logic [3:0]       w_req_wstrb;
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range, w_is_read, w_ram_en;
  logic [31:0]      w_ram_q;

  // With zero wait states the RAM access happens on the acceptance edge,
  // before the request registers hold the request, so use the live inputs.
  assign w_req_addr  = (r_state == ST_IDLE) ? s_addr  : r_addr;
  assign w_req_wdata = (r_state == ST_IDLE) ? s_wdata : r_wdata;
  assign w_req_wstrb = (r_state == ST_IDLE) ? s_wstrb : r_wstrb;

  assign w_off     = w_req_addr - BASE_ADDR;
  assign w_idx     = w_off[IDX_W+1:2];
  assign w_is_read = (w_req_wstrb == STRB_READ);

`ifdef VIGNA_BUS_RESP_ERR_EN
  // Addresses below BASE_ADDR wrap to large offsets and fail the compare.
  assign w_in_range = ({1'b0, w_off} < SPAN);
`else
  logic w_unused_off;
  assign w_in_range   = 1'b1;
  assign w_unused_off = ^{w_off[1:0], w_off[31:IDX_W+2], SPAN};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LOAD_VAL;
          end else begin
            w_state_nxt = ST_RESP;
            w_access    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ready    <= w_access;
      r_rd_valid <= w_access & w_is_read & w_in_range;
      if (w_capture) begin
        r_addr  <= s_addr;
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
      end
    end
  end

  // Reset gates the RAM so a write pending at reset is dropped.
  assign w_ram_en = w_access & w_in_range & ~reset;

  vigna_sram_1rw #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_req_wstrb),
    .i_idx   (w_idx),
    .i_wdata (w_req_wdata),
    .o_rdata (w_ram_q)
  );

  assign s_ready = r_ready;
  // RAM read register is not reset; qualify it so writes, errors and
  // idle cycles present zero.
  assign s_rdata = r_rd_valid ? w_ram_q : 32'h0;

`ifdef VIGNA_BUS_RESP_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_access & ~w_in_range;
    end
  end

  assign s_err = r_err;
`endif

endmodule
